step_pulse_monitor: RTL and testbench
=====================================

Name: step_pulse_monitor

Overview:
- Receive-side counterpart of the step pulse generator.
- Observes a STEP/DIR pulse train, for example from the generator output, an external controller, or a loopback.
- Measures step period and high width in clk cycles and maintains a signed step position.
- Reports whether the train is active, for closed-loop checking and motion-status readback.

Parameters:
CNT_W, 16, width of period/high-time counters and outputs
POS_W, 32, width of the signed step position accumulator
TIMEOUT, 50000, cycles without a detected rising edge before the train is declared stopped; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
pul_in  input  1  step pulse, asynchronous to clk
dir_in  input  1  direction, 1 = forward (+1), 0 = reverse (-1), asynchronous to clk
clr  input  1  synchronous clear of step_pos
period  output  CNT_W  last measured rise-to-rise interval in clk cycles
high_time  output  CNT_W  high width of the same pulse, in clk cycles
meas_valid  output  1  one-cycle strobe; period/high_time updated this cycle
step_pos  output  POS_W  signed step position, two's complement
moving  output  1  pulse train active

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - All registers clear: period=0, high_time=0, meas_valid=0, step_pos=0, moving=0, synchronizers 0, FSM=IDLE.
  - Reset mid-train discards partial measurements. The first rise after reset produces no meas_valid.
- Input conditioning:
  - pul_in and dir_in each pass through a 2-flop synchronizer.
  - A third history flop on pul_in gives rise = s2 & ~s3 and fall = ~s2 & s3.
  - Detection latency is 3 clk from the pul_in transition. Synchronized dir is sampled in the rise cycle.
- Counters:
  - per_cnt is loaded with 1 on the cycle after each rise and increments every cycle in HIGH/LOW. On the next rise it equals the rise-to-rise distance P.
  - hi_cnt behaves the same way, from rise until fall.
  - TIMEOUT guarantees no counter overflow.
- FSM:
  - IDLE: on rise -> HIGH; per_cnt<=1, hi_cnt<=1, moving<=1, no measurement.
  - HIGH: per_cnt++, hi_cnt++. On fall -> LOW and hi_hold<=hi_cnt.
  - LOW: per_cnt++. On rise: period<=per_cnt, high_time<=hi_hold, meas_valid<=1 (next cycle only), per_cnt<=1, hi_cnt<=1 -> HIGH.
  - Timeout, in HIGH or LOW: if per_cnt==TIMEOUT and there is no rise that cycle -> IDLE, moving<=0, no meas_valid, period/high_time hold.
  - A rise coincident with per_cnt==TIMEOUT is a normal measurement; rise wins.
  - A pulse whose fall never arrives times out from HIGH.
- Outputs hold:
  - period and high_time hold until the next valid measurement.
  - meas_valid is exactly one cycle wide per measured pulse.
- Position:
  - On every rise, including from IDLE: step_pos <= step_pos + 1 if dir=1, else step_pos - 1.
  - Arithmetic is modulo 2^POS_W and wraps silently.
- clr: step_pos <= 0. If clr and rise coincide, the result is +1 or -1 (clear, then count). clr does not affect the FSM, measurements, or moving.
- Registered outputs: all outputs are registered. There is no combinational path from any input to any output.

Test Plan:
1. Reset:
   - Stimulus: hold rst 3 cycles with pul_in toggling.
   - Required response: all outputs 0 and meas_valid never asserted; the first post-reset pulse gives step_pos=1 and no meas_valid.
2. Steady train:
   - Stimulus: period 100, high 50, dir=1, 5 pulses.
   - Required response: exactly 4 meas_valid strobes, each with period=100 and high_time=50; step_pos=5; moving=1.
3. Reverse and asymmetric duty:
   - Stimulus: dir=0, period 37, high 5, 3 pulses after test 2.
   - Required response: step_pos=2; the strobes report period=37 and high_time=5. The first strobe reports the interval spanning the train boundary.
4. Stop and restart:
   - Stimulus: TIMEOUT=200, then halt pulses.
   - Required response: moving falls exactly 200 cycles after the last rise detection. The next pulse gives no strobe; the following one strobes the correct period.
5. Clear coincidence:
   - Stimulus: assert clr on the rise-detect cycle with dir=1, and repeat with dir=0.
   - Required response: step_pos=1 and 0xFFFFFFFF respectively; measurements are unaffected.
6. Wrap and mid-train reset:
   - Stimulus: POS_W=4, 17 forward steps; then reset mid-pulse.
   - Required response: 17 forward steps give step_pos=1. After the mid-pulse reset, no strobe until two full rises are detected.

Source files
------------

// File: rtl/step_pulse_monitor_if.sv
// Bus bundle for step_pulse_monitor: STEP/DIR/clear inputs and measurement outputs.
interface step_pulse_monitor_if #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
);
  logic             pul_in;
  logic             dir_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic [POS_W-1:0] step_pos;
  logic             moving;

  modport master (
    output pul_in, dir_in, clr,
    input  period, high_time, meas_valid, step_pos, moving
  );

  modport slave (
    input  pul_in, dir_in, clr,
    output period, high_time, meas_valid, step_pos, moving
  );
endinterface

// File: rtl/step_pulse_monitor.sv
// step_pulse_monitor: observes a STEP/DIR train, measures rise-to-rise period
// and high width in clk cycles, tracks signed position and train activity.
//
// state | meaning
// IDLE  | no train; waiting for the first rise (no measurement on it)
// HIGH  | pulse is high; counting period and high width
// LOW   | pulse is low; counting period, high width held for the next rise
module step_pulse_monitor #(
  parameter int CNT_W   = 16,
  parameter int POS_W   = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst,
  step_pulse_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             pul_s1_q, pul_s2_q, pul_s3_q;
  logic             dir_s1_q, dir_s2_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic [POS_W-1:0] step_pos_q, step_pos_d;
  logic             moving_q, moving_d;

  logic             rise, fall, tmo;
  logic [POS_W-1:0] pos_base;

  assign rise = pul_s2_q & ~pul_s3_q;
  assign fall = ~pul_s2_q & pul_s3_q;
  assign tmo  = (per_cnt_q == CNT_W'(TIMEOUT));

  // Synchronizers plus all state registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pul_s1_q     <= 1'b0;
      pul_s2_q     <= 1'b0;
      pul_s3_q     <= 1'b0;
      dir_s1_q     <= 1'b0;
      dir_s2_q     <= 1'b0;
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_hold_q    <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      step_pos_q   <= '0;
      moving_q     <= 1'b0;
    end else begin
      pul_s1_q     <= bus.pul_in;
      pul_s2_q     <= pul_s1_q;
      pul_s3_q     <= pul_s2_q;
      dir_s1_q     <= bus.dir_in;
      dir_s2_q     <= dir_s1_q;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_hold_q    <= hi_hold_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      step_pos_q   <= step_pos_d;
      moving_q     <= moving_d;
    end
  end

  // Next-state logic: FSM, counters, measurement capture and position update.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    hi_hold_d    = hi_hold_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    moving_d     = moving_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HIGH;
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
          moving_d  = 1'b1;
        end
      end
      HIGH: begin
        // A fall landing on the timeout cycle still times out; only a rise rescues.
        if (tmo && !rise) begin
          state_d  = IDLE;
          moving_d = 1'b0;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(1);
          if (fall) begin
            state_d   = LOW;
            hi_hold_d = hi_cnt_q;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d      = HIGH;
          period_d     = per_cnt_q;
          high_time_d  = hi_hold_q;
          meas_valid_d = 1'b1;
          per_cnt_d    = CNT_W'(1);
          hi_cnt_d     = CNT_W'(1);
        end else if (tmo) begin
          state_d  = IDLE;
          moving_d = 1'b0;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        moving_d = 1'b0;
      end
    endcase

    // Clear first, then count, so a coincident rise lands on +1/-1.
    pos_base   = bus.clr ? '0 : step_pos_q;
    step_pos_d = pos_base;
    if (rise) begin
      step_pos_d = dir_s2_q ? (pos_base + POS_W'(1)) : (pos_base - POS_W'(1));
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.step_pos   = step_pos_q;
  assign bus.moving     = moving_q;

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Directed bench for step_pulse_monitor: a 32-bit instance with short timeout
// and a 4-bit position instance that shares the stimulus but has its own reset.
module tb_step_pulse_monitor;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_bh = 1'b1;
  logic rst_b;
  logic pul = 1'b0, dir = 1'b0, clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int tick_no = 0;
  int a_pos_tick = 0, a_fall_tick = 0;
  logic [31:0] a_prev_pos = '0;
  logic a_prev_mov = 1'b0;
  int a_strobes = 0, b_strobes = 0;
  logic [CNT_W-1:0] qp[$], qh[$];
  logic [CNT_W-1:0] b_last_p = '0, b_last_h = '0;
  int snap;

  always #5 clk = ~clk;
  assign rst_b = rst | rst_bh;

  step_pulse_monitor_if #(.CNT_W(CNT_W), .POS_W(32)) a_if ();
  step_pulse_monitor_if #(.CNT_W(CNT_W), .POS_W(4))  b_if ();

  assign a_if.pul_in = pul;
  assign a_if.dir_in = dir;
  assign a_if.clr    = clr;
  assign b_if.pul_in = pul;
  assign b_if.dir_in = dir;
  assign b_if.clr    = clr;

  step_pulse_monitor #(.CNT_W(CNT_W), .POS_W(32), .TIMEOUT(200)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );

  step_pulse_monitor #(.CNT_W(CNT_W), .POS_W(4), .TIMEOUT(200)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sample on the falling edge and log strobes, position changes and moving falls.
  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (a_if.meas_valid) begin
      a_strobes++;
      qp.push_back(a_if.period);
      qh.push_back(a_if.high_time);
    end
    if (b_if.meas_valid) begin
      b_strobes++;
      b_last_p = b_if.period;
      b_last_h = b_if.high_time;
    end
    if (a_if.step_pos != a_prev_pos) a_pos_tick = tick_no;
    if (a_prev_mov && !a_if.moving) a_fall_tick = tick_no;
    a_prev_pos = a_if.step_pos;
    a_prev_mov = a_if.moving;
  endtask

  task automatic drive(input logic p, input logic d, input logic c);
    tick();
    pul = p;
    dir = d;
    clr = c;
  endtask

  // clr_at = cycle index within the pulse at which clr is driven (-1 = never).
  task automatic pulse(input int per, input int hi, input logic d, input int clr_at);
    for (int i = 0; i < per; i++) drive(i < hi, d, i == clr_at);
  endtask

  task automatic check_strobes(input string tag, input int n, input int p, input int h);
    check({tag, "_cnt"}, qp.size(), n);
    for (int i = 0; i < qp.size(); i++) begin
      check({tag, "_per"}, qp[i], p);
      check({tag, "_hi"}, qh[i], h);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Bring-up, then a short train so reset has state to discard.
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) pulse(50, 20, 1'b1, -1);
    check("pre_pos", a_if.step_pos, 3);

    // 1. Reset mid-train with pul toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i % 2 == 0, 1'b1, 1'b0);
      if (i > 0) check("t1_mv_in_rst", a_if.meas_valid, 0);
    end
    drive(0, 1'b1, 0);
    rst = 1'b0;
    check("t1_period", a_if.period, 0);
    check("t1_high", a_if.high_time, 0);
    check("t1_mv", a_if.meas_valid, 0);
    check("t1_pos", a_if.step_pos, 0);
    check("t1_moving", a_if.moving, 0);
    snap = a_strobes;
    pulse(100, 50, 1'b1, -1);
    check("t1_first_no_strobe", a_strobes - snap, 0);
    check("t1_first_pos", a_if.step_pos, 1);
    for (int i = 0; i < 250; i++) drive(0, 1'b1, 0);
    check("t1_stopped", a_if.moving, 0);
    drive(0, 1'b1, 1'b1);
    drive(0, 1'b1, 0);
    check("clr_pos", a_if.step_pos, 0);

    // 2. Steady train.
    qp.delete(); qh.delete();
    for (int k = 0; k < 5; k++) pulse(100, 50, 1'b1, -1);
    check_strobes("t2", 4, 100, 50);
    check("t2_pos", a_if.step_pos, 5);
    check("t2_moving", a_if.moving, 1);

    // 3. Reverse, asymmetric duty; first strobe spans the boundary.
    qp.delete(); qh.delete();
    for (int k = 0; k < 3; k++) pulse(37, 5, 1'b0, -1);
    check("t3_cnt", qp.size(), 3);
    if (qp.size() == 3) begin
      check("t3_boundary_per", qp[0], 100);
      check("t3_boundary_hi", qh[0], 50);
      check("t3_per1", qp[1], 37);
      check("t3_hi1", qh[1], 5);
      check("t3_per2", qp[2], 37);
      check("t3_hi2", qh[2], 5);
    end
    check("t3_pos", a_if.step_pos, 2);

    // 4. Stop and restart.
    for (int i = 0; i < 400 && a_if.moving; i++) drive(0, 1'b1, 0);
    check("t4_stopped", a_if.moving, 0);
    check("t4_gap", a_fall_tick - a_pos_tick, 200);
    check("t4_period_hold", a_if.period, 37);
    qp.delete(); qh.delete();
    pulse(60, 20, 1'b1, -1);
    check("t4_restart_no_strobe", qp.size(), 0);
    pulse(60, 20, 1'b1, -1);
    check_strobes("t4_restart", 1, 60, 20);

    // 5. clr coincident with rise detect.
    qp.delete(); qh.delete();
    pulse(60, 20, 1'b1, 2);
    check("t5_fwd", a_if.step_pos, 1);
    pulse(60, 20, 1'b0, 2);
    check("t5_rev", a_if.step_pos, 32'hFFFF_FFFF);
    check_strobes("t5", 2, 60, 20);
    check("t5_moving", a_if.moving, 1);

    // 6. 4-bit wrap, then reset mid-pulse on the small instance.
    drive(0, 1'b1, 0);
    rst_bh = 1'b0;
    drive(0, 1'b1, 0);
    check("t6_pos0", b_if.step_pos, 0);
    for (int k = 0; k < 17; k++) pulse(20, 10, 1'b1, -1);
    check("t6_wrap", b_if.step_pos, 1);
    for (int i = 0; i < 100; i++) begin
      drive(i < 50, 1'b1, 0);
      rst_bh = (i >= 20 && i < 23);
      if (i == 23) snap = b_strobes;
    end
    check("t6_no_strobe_partial", b_strobes - snap, 0);
    check("t6_pos_partial", b_if.step_pos, 1);
    check("t6_moving", b_if.moving, 1);
    pulse(100, 50, 1'b1, -1);
    check("t6_strobe", b_strobes - snap, 1);
    check("t6_per", b_last_p, 77);
    check("t6_hi", b_last_h, 27);
    check("t6_pos_end", b_if.step_pos, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
